vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA 640x480 sync generator. Samples incoming `hsync`/`vsync` on the 25 MHz pixel enable and rebuilds `pixel_x`/`pixel_y`/`video_on` locally. Qualifies the timing with a lock state machine and flags timing errors. Sits between the design's VGA outputs and the simulator's frame-capture path, and serves as a self-check on any sync source.

## Interface
- `HD`, 640: horizontal display pixels
- `HF`, 48: horizontal front border
- `HB`, 16: horizontal back border
- `HR`, 96: horizontal retrace
- `VD`, 480: vertical display lines
- `VF`, 10: vertical front border
- `VB`, 33: vertical back border
- `VR`, 2: vertical retrace
- `LOCK_LINES`, 4: consecutive correct lines required before lock

Ports:
- `clk` in 1: system clock (50 MHz)
- `rst` in 1: asynchronous, active-low reset
- `p_tick` in 1: pixel enable, one `clk` wide, every other `clk`
- `hsync` in 1: horizontal sync, active-high
- `vsync` in 1: vertical sync, active-high
- `pixel_x` out 10: reconstructed column
- `pixel_y` out 10: reconstructed row
- `video_on` out 1: active area, only when locked
- `locked` out 1: timing qualified
- `frame_start` out 1: one-`clk` pulse at (0,0) while locked
- `sync_err` out 1: one-`clk` pulse on a timing violation

## Operation
- Derived constants: HTOTAL = HD+HF+HB+HR (800); VTOTAL = VD+VF+VB+VR (525).
- All logic advances only on `clk` edges with `p_tick`=1, except the one-`clk` pulses.
- Edge detect: `hs_q`/`vs_q` hold the previous sampled values. Rise = input 1 and `_q` 0.
- `h_count` behaviour:
  - On hsync rise, load HD+HB (656).
  - Otherwise, at HTOTAL-1, wrap to 0.
  - Otherwise, increment.
- `v_count` behaviour:
  - On vsync rise, load VD+VB (513). This has priority over a same-tick h-wrap.
  - Otherwise, on h-wrap, increment, wrapping VTOTAL-1 to 0.
- `period` counts ticks since the last hsync rise. It saturates at 1023.
- `line_cnt` counts hsync rises since the last vsync rise.
- FSM states:
  - **SEARCH**: `locked`=0. On hsync rise, clear `period` and `good`, then go to HLOCK.
  - **HLOCK**: on each hsync rise, if `period`==HTOTAL then `good`++ (saturating at LOCK_LINES), else `good`=0. On vsync rise with `good`==LOCK_LINES, go to LOCKED and clear `line_cnt`.
  - **LOCKED**: any of the following pulses `sync_err` and returns to SEARCH:
    - hsync rise with `period`≠HTOTAL;
    - `period` reaching HTOTAL+1 without an hsync rise (lost sync);
    - vsync rise with `line_cnt`≠VTOTAL.
- `video_on` = `locked` && `h_count`<HD && `v_count`<VD.
- `frame_start` pulses for one `clk` when `locked` and the counters transition to (0,0).
- Out-of-range counts never occur: loads and wraps keep `h_count`<HTOTAL and `v_count`<VTOTAL.

## Timing
- All outputs are registered.
- Latency: outputs reflect a `p_tick` sample on the next `clk`. `pixel_x` equals the generator's x delayed by one pixel period plus the source's sync buffering delay.
- Reset (`rst`=0, asynchronous): every output is 0, the FSM is in SEARCH, and all counters, `hs_q` and `vs_q` are 0.
- Reset mid-frame: the block reacquires from SEARCH. `locked` asserts at the first vsync rise after LOCK_LINES good lines.
- Counter reconstruction runs in every state, so `pixel_x`/`pixel_y` are valid once one hsync and one vsync rise have been seen.
- `p_tick` held low: all state freezes except that pending pulses clear.

## Configuration
- Macro: `VGA_SYNC_DECODER_STATS_EN`.
- Defined: adds output ports `frame_count` (16 bits; increments on each `frame_start`, wraps) and `err_count` (8 bits; increments on each `sync_err`, saturates at 255). Both reset to 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

## Test plan
- Sync generator drives the block after reset release: `locked` rises at the first vsync rise after 4 good lines. Thereafter `pixel_x`/`pixel_y` track the generator (640x480 visible), and `frame_start` pulses once per 800x525 ticks.
- Once locked, the bench compares `video_on` each tick: it is 1 for exactly 307200 ticks per frame and 0 in blanking.
- Bench suppresses one hsync pulse while locked: `sync_err` pulses once, with `period`=801, and `locked` drops to 0. Lock is reacquired on a later frame.
- Bench drives a 799-tick line: `sync_err` pulses and the FSM returns to SEARCH. `pixel_x` reloads to 656 at the next hsync rise.
- Bench asserts `rst` low mid-frame at (300,200): all outputs are 0 asynchronously. After release, lock recovers within 2 frames.
- With `VGA_SYNC_DECODER_STATS_EN` defined, run 3 clean frames plus 1 injected error: `frame_count` increments once per clean frame and `err_count`=1.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel_x / pixel_y / video_on from incoming VGA
// hsync/vsync sampled on the pixel enable, qualifies the timing with a lock
// state machine and pulses sync_err on timing violations.
// Optional statistics (frame_count, err_count) are compiled in when the
// macro VGA_SYNC_DECODER_STATS_EN is defined.
module vga_sync_decoder #(
    parameter int HD         = 640,
    parameter int HF         = 48,
    parameter int HB         = 16,
    parameter int HR         = 96,
    parameter int VD         = 480,
    parameter int VF         = 10,
    parameter int VB         = 33,
    parameter int VR         = 2,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err
`ifdef VGA_SYNC_DECODER_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
`endif
);

    localparam logic [9:0] HD_C     = 10'(HD);
    localparam logic [9:0] VD_C     = 10'(VD);
    localparam logic [9:0] HTOTAL_C = 10'(HD + HF + HB + HR);
    localparam logic [9:0] VTOTAL_C = 10'(VD + VF + VB + VR);
    localparam logic [9:0] H_LOAD_C = 10'(HD + HB);
    localparam logic [9:0] V_LOAD_C = 10'(VD + VB);
    localparam logic [9:0] SAT10_C  = 10'h3FF;
    localparam logic [7:0] LOCK_C   = 8'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       hs_q, vs_q;
    logic       hs_rise, vs_rise, h_wrap;
    logic [9:0] h_count_reg, h_count_next;
    logic [9:0] v_count_reg, v_count_next;
    logic [9:0] period_reg, period_next;
    logic [9:0] line_cnt_reg, line_cnt_next;
    logic [7:0] good_reg, good_next;
    logic       err_detect;

    logic       video_on_next, locked_next, frame_start_next;
    logic       video_on_reg, locked_reg, frame_start_reg, sync_err_reg;

    // Counter reconstruction and period / line measurement (runs in every state)
    always_comb begin
        hs_rise = hsync & ~hs_q;
        vs_rise = vsync & ~vs_q;
        h_wrap  = !hs_rise && (h_count_reg == HTOTAL_C - 10'd1);

        if (hs_rise)
            h_count_next = H_LOAD_C;
        else if (h_wrap)
            h_count_next = '0;
        else
            h_count_next = h_count_reg + 10'd1;

        // A vsync rise overrides the line increment of a same-tick h-wrap
        if (vs_rise)
            v_count_next = V_LOAD_C;
        else if (h_wrap)
            v_count_next = (v_count_reg == VTOTAL_C - 10'd1) ? 10'd0 : v_count_reg + 10'd1;
        else
            v_count_next = v_count_reg;

        // The rise tick itself is tick 1 of the new line, so a correct line
        // shows period == HTOTAL at the following rise.
        if (hs_rise)
            period_next = 10'd1;
        else if (period_reg == SAT10_C)
            period_next = period_reg;
        else
            period_next = period_reg + 10'd1;

        if (vs_rise)
            line_cnt_next = {9'd0, hs_rise};
        else if (hs_rise && line_cnt_reg != SAT10_C)
            line_cnt_next = line_cnt_reg + 10'd1;
        else
            line_cnt_next = line_cnt_reg;
    end

    // Datapath registers advance only on the pixel enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            h_count_reg  <= '0;
            v_count_reg  <= '0;
            period_reg   <= '0;
            line_cnt_reg <= '0;
        end else if (p_tick) begin
            hs_q         <= hsync;
            vs_q         <= vsync;
            h_count_reg  <= h_count_next;
            v_count_reg  <= v_count_next;
            period_reg   <= period_next;
            line_cnt_reg <= line_cnt_next;
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= SEARCH;
            good_reg  <= '0;
        end else if (p_tick) begin
            state_reg <= state_next;
            good_reg  <= good_next;
        end
    end

    // Lock FSM next-state logic and violation detection
    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        err_detect = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (hs_rise) begin
                    good_next  = '0;
                    state_next = HLOCK;
                end
            end
            HLOCK: begin
                if (hs_rise) begin
                    if (period_reg == HTOTAL_C)
                        good_next = (good_reg == LOCK_C) ? good_reg : good_reg + 8'd1;
                    else
                        good_next = '0;
                end
                if (vs_rise && good_reg == LOCK_C)
                    state_next = LOCKED;
            end
            LOCKED: begin
                // Wrong line length, missing hsync, or wrong frame height
                if ((hs_rise && period_reg != HTOTAL_C) ||
                    (!hs_rise && period_reg == HTOTAL_C) ||
                    (vs_rise && line_cnt_reg != VTOTAL_C)) begin
                    err_detect = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Lock FSM output logic (values to be registered on this tick)
    always_comb begin
        locked_next      = (state_next == LOCKED);
        video_on_next    = locked_next && (h_count_next < HD_C) && (v_count_next < VD_C);
        frame_start_next = locked_next && (h_count_next == 10'd0) && (v_count_next == 10'd0) &&
                           ((h_count_reg != 10'd0) || (v_count_reg != 10'd0));
    end

    // Output registers; pulses are rebuilt every clk so they last one clk only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            video_on_reg    <= 1'b0;
            locked_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            frame_start_reg <= p_tick && frame_start_next;
            sync_err_reg    <= p_tick && err_detect;
            if (p_tick) begin
                video_on_reg <= video_on_next;
                locked_reg   <= locked_next;
            end
        end
    end

    assign pixel_x     = h_count_reg;
    assign pixel_y     = v_count_reg;
    assign video_on    = video_on_reg;
    assign locked      = locked_reg;
    assign frame_start = frame_start_reg;
    assign sync_err    = sync_err_reg;

`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [15:0] frame_count_reg;
    logic [7:0]  err_count_reg;

    // Frame counter wraps; error counter saturates so it never reads as clean
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count_reg <= '0;
            err_count_reg   <= '0;
        end else begin
            if (p_tick && frame_start_next)
                frame_count_reg <= frame_count_reg + 16'd1;
            if (p_tick && err_detect && err_count_reg != 8'hFF)
                err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign frame_count = frame_count_reg;
    assign err_count   = err_count_reg;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced raster (32x15 ticks, 20x8
// visible) so several frames fit in a short run. A behavioural sync source
// drives the block; directed disturbances: a suppressed hsync pulse, a line
// one tick short, a p_tick freeze and an asynchronous reset mid-frame.
// Define VGA_SYNC_DECODER_STATS_EN to also check frame_count / err_count.
module tb_vga_sync_decoder;

    localparam int HD = 20, HF = 6, HB = 2, HR = 4;
    localparam int VD = 8, VF = 2, VB = 3, VR = 2;
    localparam int LOCK_LINES = 4;
    localparam int HTOTAL  = HD + HF + HB + HR;   // 32
    localparam int VTOTAL  = VD + VF + VB + VR;   // 15
    localparam int HS_BEG  = HD + HB;             // 22
    localparam int VS_BEG  = VD + VB;             // 11

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_tick = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, locked, frame_start, sync_err;
`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`endif

    vga_sync_decoder #(
        .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR),
        .LOCK_LINES(LOCK_LINES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_tick      (p_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err)
`ifdef VGA_SYNC_DECODER_STATS_EN
        ,
        .frame_count (frame_count),
        .err_count   (err_count)
`endif
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Source raster position and expected-behaviour model
    int gx = 0, gy = 0, fr = 0;
    bit hs_prev = 0, vs_prev = 0;
    bit exp_locked = 0;
    int rises_since = 0;
    bit track_x = 0, track_y = 0, skip_win = 0;
    int exp_fc = 0, exp_ec = 0;
    int vo_cnt = 0;
    bit did_reset = 0, did_freeze = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (frame %0d x %0d y %0d t=%0t)",
                     tag, obs, exp, fr, gx, gy, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_x"}, pixel_x, 0);
        check({tag, "_pixel_y"}, pixel_y, 0);
        check({tag, "_video_on"}, video_on, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_sync_err"}, sync_err, 0);
`ifdef VGA_SYNC_DECODER_STATS_EN
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    // One pixel period: drive the source, pulse p_tick, check, advance raster
    task automatic do_tick();
        bit killed, hs_now, vs_now, hs_rise_e, vs_rise_e, exp_err, exp_fs, exp_vo;
        killed    = (fr == 3 && gy == 3);
        hs_now    = (gx >= HS_BEG && gx < HS_BEG + HR) && !killed;
        vs_now    = (gy >= VS_BEG && gy < VS_BEG + VR);
        hs_rise_e = hs_now && !hs_prev;
        vs_rise_e = vs_now && !vs_prev;
        exp_err   = exp_locked &&
                    ((killed && gx == HS_BEG) || (fr == 5 && gy == 10 && hs_rise_e));

        if (exp_err) begin
            exp_locked  = 0;
            rises_since = 0;
            exp_ec++;
        end else begin
            if (hs_rise_e) rises_since++;
            if (!exp_locked && vs_rise_e && rises_since >= LOCK_LINES + 1) exp_locked = 1;
        end
        if (hs_rise_e) begin
            track_x  = 1;
            skip_win = 0;
        end
        if (vs_rise_e) track_y = 1;
        exp_fs = exp_locked && gx == 0 && gy == 0;
        exp_vo = exp_locked && gx < HD && gy < VD;
        if (exp_fs) exp_fc++;

        hsync  = hs_now;
        vsync  = vs_now;
        p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0;
        check("locked", locked, exp_locked);
        check("video_on", video_on, exp_vo);
        check("frame_start", frame_start, exp_fs);
        check("sync_err", sync_err, exp_err);
        if (track_x && !skip_win) check("pixel_x", pixel_x, gx);
        if (track_y && !skip_win) check("pixel_y", pixel_y, gy);
        if (exp_err && fr == 5) check("reload_x", pixel_x, HS_BEG);
        if (fr == 1 || fr == 4) vo_cnt += int'(video_on);
        if (exp_err) $display("sync error expected at frame %0d line %0d x %0d", fr, gy, gx);

        @(posedge clk); #1;
        if (exp_err || exp_fs) begin
            check("pulse_clear_fs", frame_start, 0);
            check("pulse_clear_err", sync_err, 0);
        end

        hs_prev = hs_now;
        vs_prev = vs_now;
        gx++;
        if (fr == 5 && gy == 9 && gx == 27) begin
            gx       = 28;   // one tick short line
            skip_win = 1;
        end
        if (gx == HTOTAL) begin
            gx = 0;
            gy++;
            if (gy == VTOTAL) begin
                gy = 0;
                if (fr == 1 || fr == 4) check("vo_per_frame", vo_cnt, HD * VD);
                vo_cnt = 0;
                $display("frame %0d done: locked=%0d checks=%0d", fr, locked, checks);
                fr++;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        while (fr < 9) begin
            if (fr == 1 && gy == 2 && gx == 5 && !did_freeze) begin
                did_freeze = 1;
                // Sync activity without p_tick must be ignored
                hsync = 1'b1;
                vsync = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                hsync = 1'b0;
                vsync = 1'b0;
                check("freeze_x", pixel_x, gx - 1);
                check("freeze_y", pixel_y, gy);
                check("freeze_vo", video_on, 1);
                check("freeze_locked", locked, 1);
                $display("p_tick freeze at frame %0d line %0d", fr, gy);
            end
            if (fr == 7 && gy == 5 && gx == 10 && !did_reset) begin
                did_reset = 1;
                check("prereset_locked", locked, 1);
`ifdef VGA_SYNC_DECODER_STATS_EN
                check("prereset_frame_count", frame_count, exp_fc);
                check("prereset_err_count", err_count, exp_ec);
`endif
                #3 rst = 1'b0;
                #1 check_all_zero("midreset");
                @(posedge clk); #1;
                rst         = 1'b1;
                hs_prev     = 0;
                vs_prev     = 0;
                exp_locked  = 0;
                rises_since = 0;
                track_x     = 0;
                track_y     = 0;
                skip_win    = 0;
                exp_fc      = 0;
                exp_ec      = 0;
                $display("mid-frame reset at frame %0d line %0d x %0d", fr, gy, gx);
            end
            do_tick();
        end

`ifdef VGA_SYNC_DECODER_STATS_EN
        check("final_frame_count", frame_count, exp_fc);
        check("final_err_count", err_count, exp_ec);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
